// File: rtl/xadc_drp_seq_axis_adapter_pkg.sv
// Shared TeachEE XADC definitions: DRP address type, sequencer state enum,
// well-known auxiliary channel addresses and the sample FIFO entry layout.
package teachee_defs;

  // 7-bit DRP register address.
  typedef logic [6:0] xadc_drp_addr_t;

  // Result registers of the auxiliary inputs wired on the TeachEE board.
  localparam xadc_drp_addr_t XADC_VAUX4_ADDR  = 7'h14;
  localparam xadc_drp_addr_t XADC_VAUX12_ADDR = 7'h1C;

  // The chan field is sized for the largest supported list (16 channels).
  localparam int XADC_CHAN_W = 4;

  // Word written into the sample FIFO when a DRP read times out.
  localparam logic [15:0] XADC_TIMEOUT_WORD = 16'hFFFF;

  // DRP read sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RDY
  } xadc_seq_state_t;

  // One buffered sample beat.
  typedef struct packed {
    logic [15:0]            data;
    logic [XADC_CHAN_W-1:0] chan;
    logic                   err;
    logic                   last;
  } xadc_fifo_entry_t;

endpackage

// File: rtl/xadc_drp_seq_axis_adapter_fifo.sv
// xadc_sample_fifo: synchronous FIFO with a registered head register that
// drives the stream outputs directly. Entries beyond the head live in a
// small circular buffer. free_count counts the head register as occupied,
// so total capacity is exactly DEPTH. Async active-low reset.
module xadc_sample_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   free_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] mem_count;

  logic pop;
  logic load_head;
  logic from_mem;
  logic wr_ok;
  logic bypass;
  logic to_mem;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) ptr_inc = '0;
    else                        ptr_inc = p + 1'b1;
  endfunction

  // A write into an empty buffer goes straight to the head register so the
  // beat is visible the cycle after the write.
  assign pop        = rd_valid && rd_ready;
  assign load_head  = !rd_valid || pop;
  assign from_mem   = load_head && (mem_count != '0);
  assign wr_ok      = wr_en && ((free_count != '0) || pop);
  assign bypass     = load_head && (mem_count == '0) && wr_ok;
  assign to_mem     = wr_ok && !bypass;
  assign free_count = CNT_W'(DEPTH) - mem_count - CNT_W'(rd_valid);

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (to_mem) mem[wr_ptr] <= wr_data;
  end

  // Pointer, occupancy and head register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (to_mem) wr_ptr <= ptr_inc(wr_ptr);
      if (from_mem) rd_ptr <= ptr_inc(rd_ptr);
      if (to_mem && !from_mem)      mem_count <= mem_count + 1'b1;
      else if (from_mem && !to_mem) mem_count <= mem_count - 1'b1;
      if (load_head) begin
        if (from_mem) begin
          rd_data  <= mem[rd_ptr];
          rd_valid <= 1'b1;
        end else if (bypass) begin
          rd_data  <= wr_data;
          rd_valid <= 1'b1;
        end else begin
          rd_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/xadc_drp_seq_axis_adapter.sv
// xadc_drp_seq_axis_adapter: on each XADC end-of-sequence pulse, reads
// NUM_CHANNELS DRP result registers and queues one AXI-Stream beat per
// channel (tuser = {err, channel}, tlast on the final channel).
// Optional feature macro: XADC_DRP_TIMEOUT_EN enables a DRP_TIMEOUT-cycle
// watchdog in WAIT_RDY that writes an error beat of 16'hFFFF.
// Stream handshake: a beat transfers on a rising edge where m_axis_tvalid
// and m_axis_tready are both high; while tvalid is high and tready low the
// beat (tdata/tuser/tlast) is held stable and tvalid stays high.
module xadc_drp_seq_axis_adapter
  import teachee_defs::*;
#(
  parameter int                      NUM_CHANNELS  = 2,
  parameter logic [NUM_CHANNELS*7-1:0] CHANNEL_ADDRS = {XADC_VAUX12_ADDR, XADC_VAUX4_ADDR},
  parameter int                      FIFO_DEPTH    = 8,
  parameter int                      DRP_TIMEOUT   = 64,
  localparam int                     CH_W          = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic            xadc_dclk,
  input  logic            xadc_reset_n,
  input  logic            xadc_eos,
  output logic [6:0]      xadc_daddr,
  output logic            xadc_den,
  input  logic            xadc_drdy,
  input  logic [15:0]     xadc_do,
  output logic [15:0]     m_axis_tdata,
  output logic [CH_W:0]   m_axis_tuser,
  output logic            m_axis_tlast,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  output logic [15:0]     overrun_count,
  output logic            busy
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] SEQ_ENTRIES = CNT_W'(NUM_CHANNELS);
  localparam logic [CH_W-1:0]  LAST_IDX    = CH_W'(NUM_CHANNELS - 1);

  xadc_seq_state_t   state;
  logic [CH_W-1:0]   idx;
  logic [CNT_W-1:0]  free_count;
  logic              timeout;
  logic              resp;
  logic              is_last;
  logic              eos_drop;
  xadc_fifo_entry_t  wr_entry;
  xadc_fifo_entry_t  head;
  logic [$bits(xadc_fifo_entry_t)-1:0] head_bits;
  logic              unused_chan_hi;

  // Address of channel i from the packed address list.
  function automatic xadc_drp_addr_t chan_addr(input logic [CH_W-1:0] i);
    chan_addr = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (i == CH_W'(k)) chan_addr = CHANNEL_ADDRS[k*7 +: 7];
    end
  endfunction

`ifdef XADC_DRP_TIMEOUT_EN
  localparam int TMO_W = $clog2(DRP_TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Watchdog: held at zero outside WAIT_RDY, counts cycles spent waiting.
  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n)          tmo_cnt <= '0;
    else if (state != WAIT_RDY) tmo_cnt <= '0;
    else if (!timeout)          tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout = (state == WAIT_RDY) && (tmo_cnt == TMO_W'(DRP_TIMEOUT - 1));
`else
  localparam int unused_drp_timeout = DRP_TIMEOUT;
  assign timeout = 1'b0;
`endif

  // A real response always wins over a coincident timeout.
  assign resp     = (state == WAIT_RDY) && (xadc_drdy || timeout);
  assign is_last  = (idx == LAST_IDX);
  assign eos_drop = xadc_eos && ((state != IDLE) || (free_count < SEQ_ENTRIES));

  // FIFO write entry formed from the DRP response of the current channel.
  always_comb begin
    wr_entry      = '0;
    wr_entry.err  = !xadc_drdy && timeout;
    wr_entry.data = wr_entry.err ? XADC_TIMEOUT_WORD : xadc_do;
    wr_entry.chan = XADC_CHAN_W'(idx);
    wr_entry.last = is_last;
  end

  // DRP read sequencer with registered DRP outputs, busy and overrun counter.
  always_ff @(posedge xadc_dclk or negedge xadc_reset_n) begin
    if (!xadc_reset_n) begin
      state         <= IDLE;
      idx           <= '0;
      xadc_daddr    <= '0;
      xadc_den      <= 1'b0;
      busy          <= 1'b0;
      overrun_count <= '0;
    end else begin
      xadc_den <= 1'b0;
      if (eos_drop && (overrun_count != 16'hFFFF)) overrun_count <= overrun_count + 1'b1;
      case (state)
        IDLE: begin
          if (xadc_eos && !eos_drop) begin
            idx        <= '0;
            xadc_daddr <= chan_addr('0);
            xadc_den   <= 1'b1;
            busy       <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (resp) begin
            if (is_last) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              idx        <= idx + 1'b1;
              xadc_daddr <= chan_addr(idx + 1'b1);
              xadc_den   <= 1'b1;
              state      <= ISSUE;
            end
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  xadc_sample_fifo #(
    .WIDTH ($bits(xadc_fifo_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (xadc_dclk),
    .rst_n      (xadc_reset_n),
    .wr_en      (resp),
    .wr_data    (wr_entry),
    .rd_ready   (m_axis_tready),
    .rd_valid   (m_axis_tvalid),
    .rd_data    (head_bits),
    .free_count (free_count)
  );

  // Unpack the registered head entry onto the stream outputs.
  always_comb begin
    head         = xadc_fifo_entry_t'(head_bits);
    m_axis_tdata = head.data;
    m_axis_tuser = {head.err, head.chan[CH_W-1:0]};
    m_axis_tlast = head.last;
  end

  assign unused_chan_hi = ^head.chan;

endmodule

// File: doc/xadc_drp_seq_axis_adapter.md
# xadc_drp_seq_axis_adapter

Parametrised successor to the two-channel XADC DRP adapter. On every XADC end-of-sequence pulse it reads a configurable list of DRP result registers and emits one AXI-Stream beat per channel. Beats are tagged with the channel index and buffered in a small FIFO, so downstream stalls never block DRP reads. It sits between the XADC wizard core and the TeachEE sample packetiser, all in the `xadc_dclk` domain.

## Interface
Parameters:
- `NUM_CHANNELS`, 2: DRP registers read per sequence, 1..16.
- `CHANNEL_ADDRS`, {7'h1C, 7'h14}: packed `NUM_CHANNELS`×7 array; slice [6:0] is channel 0 (default ch0 = VAUX4, ch1 = VAUX12).
- `FIFO_DEPTH`, 8: output FIFO entries; power of 2, ≥ `NUM_CHANNELS`.
- `DRP_TIMEOUT`, 64: cycles to wait for `xadc_drdy`; used only with the macro below.

Ports (`CH_W` = max(1, $clog2(`NUM_CHANNELS`))):
- `xadc_dclk` in 1: sole clock.
- `xadc_reset_n` in 1: asynchronous, active-low reset.
- `xadc_eos` in 1: end-of-sequence pulse from XADC.
- `xadc_daddr` out 7: DRP address.
- `xadc_den` out 1: DRP enable, single-cycle pulse.
- `xadc_drdy` in 1: DRP read data valid.
- `xadc_do` in 16: DRP read data.
- `m_axis_tdata` out 16: raw DRP word (12-bit result in [15:4]).
- `m_axis_tuser` out `CH_W`+1: [CH_W-1:0] channel index, [CH_W] error flag.
- `m_axis_tlast` out 1: high on the last channel of a sequence.
- `m_axis_tvalid` out 1, `m_axis_tready` in 1: AXI-Stream handshake.
- `overrun_count` out 16: dropped sequences, saturating.
- `busy` out 1: high while a DRP sequence is in progress.

## Operation
- FSM states are IDLE, ISSUE and WAIT_RDY, with channel index `idx`.
- IDLE, `xadc_eos`=1, FIFO free entries ≥ `NUM_CHANNELS`: `idx`←0, go to ISSUE.
- IDLE, `xadc_eos`=1, free entries < `NUM_CHANNELS`: `overrun_count`++ (saturates at 16'hFFFF), stay in IDLE. Partial sequences are never written.
- ISSUE: `xadc_den`=1 for one cycle with `xadc_daddr`=`CHANNEL_ADDRS[idx]`, then go to WAIT_RDY. `xadc_daddr` holds its value until the next ISSUE.
- WAIT_RDY, `xadc_drdy`=1: write {`xadc_do`, `idx`, err=0, last=(`idx`==N-1)} to the FIFO.
  - Last channel: go to IDLE.
  - Otherwise: `idx`++, go to ISSUE.
- `xadc_drdy` in IDLE or ISSUE is ignored. This covers stale responses after a timeout or reset.
- `xadc_eos` in ISSUE or WAIT_RDY: `overrun_count`++; the active sequence continues unaffected.
- The reservation check happens at EOS. The FSM is the only writer, so the FIFO can never overflow mid-sequence.
- FIFO output: `m_axis_*` presents the head entry. Pop on `tvalid && tready`. The beat is held stable while `tvalid && !tready`.
- Simultaneous write and pop on a full or empty FIFO are both legal; the occupancy count stays consistent.

## Timing
- Reset values: `xadc_den`=0, `xadc_daddr`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tuser`=0, `m_axis_tlast`=0, `overrun_count`=0, `busy`=0. The FIFO is empty and the FSM is in IDLE.
- Reset asserted mid-sequence clears everything immediately and discards buffered beats.
- `xadc_eos` high at edge t → `xadc_den` high during cycle t+1.
- `xadc_drdy` at edge d → next `xadc_den` during cycle d+1.
- Into an empty FIFO, a write at edge d gives `m_axis_tvalid` high during cycle d+1.
- Back-to-back throughput with `tready`=1 is one beat per DRP round-trip. The FIFO sustains one beat per cycle.
- `busy` is high in ISSUE and WAIT_RDY.

## Configuration
- `XADC_DRP_TIMEOUT_EN` defined:
  - A counter clears on entering WAIT_RDY.
  - If `DRP_TIMEOUT` cycles pass without `xadc_drdy`, the block writes {16'hFFFF, `idx`, err=1, last} and advances exactly as on `xadc_drdy`.
- `XADC_DRP_TIMEOUT_EN` undefined:
  - No counter is built and the error bit is tied 0.
  - WAIT_RDY waits indefinitely.

## Structure
- `teachee_defs` holds:
  - the existing `xadc_drp_addr_t`;
  - the new `xadc_seq_state_t` enum (IDLE/ISSUE/WAIT_RDY);
  - `XADC_VAUX4_ADDR`=7'h14 and `XADC_VAUX12_ADDR`=7'h1C;
  - the FIFO entry struct {data, chan, err, last}.
- Sub-module `xadc_sample_fifo`: synchronous FIFO parametrised by width and depth. It has a registered-output head, a `free_count` output for the reservation check, and async active-low reset.

## Test plan
- Defaults, `tready`=1, BFM returns 16'h1230 @7'h14 and 16'h4560 @7'h1C; one EOS → exactly 2 `xadc_den` pulses, beats (1230, ch0, last 0) then (4560, ch1, last 1), `busy` back to 0.
- `tready`=0, N=2, depth 8: four EOS fill the FIFO; fifth EOS → `overrun_count`=1 and no `xadc_den`. Then `tready`=1 → 8 beats in order with tlast on every second beat.
- EOS pulsed while in WAIT_RDY → `overrun_count`=1; current sequence still delivers both beats intact.
- `tready` toggled every cycle over 3 sequences → 6 beats, none lost or duplicated, tdata/tuser stable while stalled.
- Macro defined, BFM withholds drdy for ch1 → after 64 cycles beat (FFFF, ch1, err 1, last 1); a later EOS works normally. Macro undefined → `busy` stays 1.
- Reset asserted during WAIT_RDY with 3 beats buffered → all outputs 0 at once. A late drdy is ignored; the next EOS yields a correct 2-beat sequence.
